// File: rtl/csa_seq_adder_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : csa_ctrl_pkg
//  Description : Shared types and helpers for the sequential carry-skip adder
//                controller: FSM state encoding, nibble width constant and
//                the nibble propagate function.
//  Optional    : none (CSA_SUB_EN is handled in the interface and controller)
//  Revision    : 1.0 - initial release
// ============================================================================
package csa_ctrl_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A nibble propagates its carry-in unchanged when every bit pair differs.
    function automatic logic nibble_propagate(input logic [NIBBLE_W-1:0] a,
                                              input logic [NIBBLE_W-1:0] b);
        return &(a ^ b);
    endfunction

endpackage
`default_nettype wire

// File: rtl/csa_seq_adder_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : csa_seq_adder_ctrl_if
//  Description : Operand/result handshake bundle for csa_seq_adder_ctrl.
//                master = operand source / result consumer side
//                slave  = controller side
//  Signals     : in_valid, in_ready, a, b, c_in, [sub], out_valid,
//                out_ready, sum, c_out, skip_mask
//  Optional    : CSA_SUB_EN adds the 1-bit 'sub' operand-side signal
//  Revision    : 1.0 - initial release
// ============================================================================
interface csa_seq_adder_ctrl_if #(
    parameter int WIDTH = 16
) ();
    localparam int NIBBLES = WIDTH / 4;

    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               c_in;
`ifdef CSA_SUB_EN
    logic               sub;
`endif
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   sum;
    logic               c_out;
    logic [NIBBLES-1:0] skip_mask;

`ifdef CSA_SUB_EN
    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, sum, c_out, skip_mask
    );
    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, sum, c_out, skip_mask
    );
`else
    modport master (
        output in_valid, a, b, c_in, out_ready,
        input  in_ready, out_valid, sum, c_out, skip_mask
    );
    modport slave (
        input  in_valid, a, b, c_in, out_ready,
        output in_ready, out_valid, sum, c_out, skip_mask
    );
`endif

endinterface
`default_nettype wire

// File: rtl/csa_seq_adder_ctrl_slice.sv
`default_nettype none
// ============================================================================
//  Module      : csa_nibble_slice
//  Description : Combinational 4-bit carry-skip adder slice.
//  Ports       : a, b      - nibble operands
//                cin       - carry into the nibble
//                sum       - nibble sum
//                c_ripple  - carry out of the ripple chain
//                p         - nibble propagate (a ^ b == 4'hF)
//                c_out     - selected carry (cin when skipping, else ripple)
//  Revision    : 1.0 - initial release
// ============================================================================
module csa_nibble_slice
    import csa_ctrl_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                c_ripple,
    output logic                p,
    output logic                c_out
);

    always_comb begin
        {c_ripple, sum} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};
    end

    assign p     = nibble_propagate(a, b);
    assign c_out = p ? cin : c_ripple;

endmodule
`default_nettype wire

// File: rtl/csa_seq_adder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : csa_seq_adder_ctrl
//  Description : Adds two WIDTH-bit operands by reusing a single 4-bit
//                carry-skip slice for WIDTH/4 cycles, low nibble first.
//                A carry register links successive nibbles; a per-nibble
//                skip mask records which nibbles took the bypass path.
//  Ports       : clk       - rising-edge clock
//                rst       - synchronous active-high reset
//                bus       - csa_seq_adder_ctrl_if.slave handshake bundle
//  Parameters  : WIDTH     - operand width, multiple of 4 and >= 4
//                NIBBLES   - derived WIDTH/4, do not override
//  Optional    : CSA_SUB_EN - adds 'sub'; when set computes a - b
//                (slice sees ~b, initial carry 1, c_out = no borrow)
//  Revision    : 1.0 - initial release
// ============================================================================
module csa_seq_adder_ctrl
    import csa_ctrl_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int NIBBLES = WIDTH / 4
) (
    input  logic                clk,
    input  logic                rst,
    csa_seq_adder_ctrl_if.slave bus
);

    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NIBBLES - 1);

    generate
        if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
            $error("csa_seq_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
        end
        if (NIBBLES != WIDTH / NIBBLE_W) begin : g_bad_nibbles
            $error("csa_seq_adder_ctrl: NIBBLES must equal WIDTH/4");
        end
    endgenerate

    state_t               r_state;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;          // already inverted for subtraction
    logic                 r_carry;
    logic [IDX_W-1:0]     r_idx;
    logic [WIDTH-1:0]     r_sum;
    logic                 r_c_out;
    logic [NIBBLES-1:0]   r_skip;
    logic                 r_in_ready;
    logic                 r_out_valid;

    logic [NIBBLE_W-1:0]  w_a_nib;
    logic [NIBBLE_W-1:0]  w_b_nib;
    logic [NIBBLE_W-1:0]  w_sum_nib;
    logic                 w_c_ripple;
    logic                 w_p;
    logic                 w_c_sel;
    logic [WIDTH-1:0]     w_b_op;
    logic                 w_cin0;
    logic                 w_in_ready;
    logic                 w_accept;

    // Operand conditioning at acceptance time.
`ifdef CSA_SUB_EN
    assign w_b_op = bus.sub ? ~bus.b : bus.b;
    assign w_cin0 = bus.sub | bus.c_in;
`else
    assign w_b_op = bus.b;
    assign w_cin0 = bus.c_in;
`endif

    // in_ready must drop immediately while reset is held, not one edge later.
    assign w_in_ready = r_in_ready & ~rst;
    assign w_accept   = bus.in_valid & w_in_ready;

    // Nibble select for the single shared slice.
    always_comb begin
        w_a_nib = '0;
        w_b_nib = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_a_nib = r_a[i*NIBBLE_W +: NIBBLE_W];
                w_b_nib = r_b[i*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    csa_nibble_slice u_slice (
        .a        (w_a_nib),
        .b        (w_b_nib),
        .cin      (r_carry),
        .sum      (w_sum_nib),
        .c_ripple (w_c_ripple),
        .p        (w_p),
        .c_out    (w_c_sel)
    );

    // The skip path must never change the arithmetic: a propagating nibble
    // ripples its carry-in straight through.
    always_comb begin
        if (!rst && r_state == RUN && w_p) begin
            assert (w_c_ripple == r_carry);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_sum       <= '0;
            r_c_out     <= 1'b0;
            r_skip      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a        <= bus.a;
                        r_b        <= w_b_op;
                        r_carry    <= w_cin0;
                        r_idx      <= '0;
                        r_sum      <= '0;
                        r_skip     <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (r_idx == IDX_W'(i)) begin
                            r_sum[i*NIBBLE_W +: NIBBLE_W] <= w_sum_nib;
                            r_skip[i]                     <= w_p;
                        end
                    end
                    r_carry <= w_c_sel;
                    r_idx   <= r_idx + IDX_W'(1);
                    if (r_idx == C_LAST_IDX) begin
                        r_c_out     <= w_c_sel;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    // Return to IDLE first so a new operand is never taken
                    // on the same edge as the result handshake.
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.sum       = r_sum;
    assign bus.c_out     = r_c_out;
    assign bus.skip_mask = r_skip;

endmodule
`default_nettype wire

// File: tb/tb_csa_seq_adder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_csa_seq_adder_ctrl
//  Description : Directed self-checking bench for csa_seq_adder_ctrl with
//                hand-computed expected results.
//  Optional    : CSA_SUB_EN enables the subtraction vectors
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_csa_seq_adder_ctrl;

    localparam int WIDTH   = 16;
    localparam int NIBBLES = WIDTH / 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    csa_seq_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

    csa_seq_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [15:0] e_sum,
                             input logic e_cout, input logic [3:0] e_mask);
        check({tag, "_sum"},  32'(bus.sum),       32'(e_sum));
        check({tag, "_cout"}, 32'(bus.c_out),     32'(e_cout));
        check({tag, "_mask"}, 32'(bus.skip_mask), 32'(e_mask));
    endtask

    // Waits for out_valid, counting edges; bounded so a stuck DUT still ends.
    task automatic wait_valid(output int n);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            tick;
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic [15:0] e_sum,
                          input logic e_cout, input logic [3:0] e_mask);
        int n;
        check({tag, "_ready_idle"}, 32'(bus.in_ready), 32'd1);
        bus.a        = a;
        bus.b        = b;
        bus.c_in     = cin;
        bus.in_valid = 1'b1;
        tick;
        bus.in_valid = 1'b0;
        bus.a        = 16'hDEAD;
        bus.b        = 16'hBEEF;
        bus.c_in     = ~cin;
        check({tag, "_ready_busy"}, 32'(bus.in_ready), 32'd0);
        wait_valid(n);
        check({tag, "_latency"}, 32'(n), 32'(NIBBLES));
        check_out(tag, e_sum, e_cout, e_mask);
        bus.out_ready = 1'b1;
        tick;
        bus.out_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.c_in      = 1'b0;
        bus.out_ready = 1'b0;
`ifdef CSA_SUB_EN
        bus.sub       = 1'b0;
`endif

        // Reset state
        tick;
        tick;
        check("rst_ready",   32'(bus.in_ready),  32'd0);
        check("rst_valid",   32'(bus.out_valid), 32'd0);
        check_out("rst", 16'h0000, 1'b0, 4'b0000);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(bus.in_ready), 32'd1);

        // Every nibble propagates: carry-in skips all the way to c_out
        run_op("all_skip", 16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1, 4'b1111);

        // Carry generated in nibble 0, upper nibbles skip
        run_op("wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 4'b1110);

        // Back-to-back: in_valid stays high through the whole first operation
        bus.a = 16'h1234; bus.b = 16'h4321; bus.c_in = 1'b0;
        bus.in_valid = 1'b1;
        tick;
        bus.a = 16'h0001; bus.b = 16'h0002; bus.c_in = 1'b0;
        wait_valid(n);
        check("b2b_latency", 32'(n), 32'd4);
        check_out("b2b_first", 16'h5555, 1'b0, 4'b0000);
        check("b2b_done_ready", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        tick;
        bus.out_ready = 1'b0;
        check("b2b_hs_valid", 32'(bus.out_valid), 32'd0);
        check("b2b_hs_ready", 32'(bus.in_ready), 32'd1);
        tick;
        bus.in_valid = 1'b0;
        check("b2b_second_accept", 32'(bus.in_ready), 32'd0);
        wait_valid(n);
        check("b2b_second_latency", 32'(n), 32'd4);
        check_out("b2b_second", 16'h0003, 1'b0, 4'b0000);
        bus.out_ready = 1'b1;
        tick;
        bus.out_ready = 1'b0;

        // Back-pressure in DONE for 5 cycles
        bus.a = 16'hFFFF; bus.b = 16'h0001; bus.c_in = 1'b0;
        bus.in_valid = 1'b1;
        tick;
        bus.in_valid = 1'b0;
        wait_valid(n);
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", 32'(bus.out_valid), 32'd1);
            check("hold_ready", 32'(bus.in_ready),  32'd0);
            check_out("hold", 16'h0000, 1'b1, 4'b1110);
            tick;
        end
        bus.out_ready = 1'b1;
        tick;
        bus.out_ready = 1'b0;
        check("release_valid", 32'(bus.out_valid), 32'd0);
        check("release_ready", 32'(bus.in_ready),  32'd1);

        // Reset while nibble 2 is in the slice
        bus.a = 16'h0F0F; bus.b = 16'hF0F0; bus.c_in = 1'b1;
        bus.in_valid = 1'b1;
        tick;
        bus.in_valid = 1'b0;
        tick;
        tick;
        rst = 1'b1;
        tick;
        check("midrst_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_ready", 32'(bus.in_ready),  32'd0);
        check_out("midrst", 16'h0000, 1'b0, 4'b0000);
        rst = 1'b0;
        #1;
        run_op("after_rst", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 4'b0010);

`ifdef CSA_SUB_EN
        // Subtraction: c_in is ignored, c_out = 1 means no borrow
        bus.sub = 1'b1;
        run_op("sub_borrow", 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 4'b1110);
        run_op("sub_ok",     16'h0007, 16'h0005, 1'b0, 16'h0002, 1'b1, 4'b1110);
        bus.sub = 1'b0;
        run_op("sub_off",    16'h0007, 16'h0005, 1'b1, 16'h000D, 1'b0, 4'b0000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
